ps2_voice_tracker: RTL and testbench

- Converts the raw PS/2 keyboard byte stream from PS2_Comm into a set of held-key voice slots for polyphonic tone generation.
- Successor to the single-byte path into the audio block: decodes make, break (F0) and extended (E0) prefixes.
- Tracks up to NUM_VOICES simultaneously held keys, with a selectable voice-stealing mode.
- Sits between PS2_Comm and the audio tone generators; last_code also feeds hexdisplay.

---
 rtl/ps2_voice_tracker.sv | 225 ++++++++++++++++++++++
 tb/tb_ps2_voice_tracker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_voice_tracker.sv
// PS/2 byte-stream decoder that maps held keys onto a small table of voice slots.
// Handles E0/F0 prefixes, typematic repeats, prefix timeout and oldest-slot stealing.
module ps2_voice_tracker #(
    parameter int unsigned NUM_VOICES  = 4,
    parameter int unsigned STEAL       = 1,
    parameter int unsigned TIMEOUT_CYC = 2500000
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic                    all_off,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [9*NUM_VOICES-1:0] voice_code,
    output logic [7:0]              last_code,
    output logic                    note_on,
    output logic                    note_off,
    output logic [2:0]              event_slot,
    output logic                    dropped
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_E0   = 2'd1;
    localparam logic [1:0] S_F0   = 2'd2;
    localparam logic [1:0] S_E0F0 = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [TW-1:0]               tmo_q, tmo_d;
    logic [NUM_VOICES-1:0]       active_q, active_d;
    logic [NUM_VOICES-1:0][8:0]  code_q, code_d;
    logic [NUM_VOICES-1:0][2:0]  age_q, age_d;
    logic [7:0]                  last_code_q, last_code_d;
    logic                        note_on_q, note_on_d;
    logic                        note_off_q, note_off_d;
    logic [2:0]                  event_slot_q, event_slot_d;
    logic                        dropped_q, dropped_d;

    logic       ignored;
    logic       is_make;
    logic       is_break;
    logic       ev_ext;
    logic [8:0] key;
    logic       hit;
    logic [2:0] hit_idx;
    logic [2:0] hit_age;
    logic       have_free;
    logic [2:0] free_idx;
    logic [2:0] old_idx;
    logic [2:0] tgt_idx;

    // Byte decode: classifies the incoming byte against the prefix state.
    always_comb begin
        ignored  = (rx_data == 8'h00) || (rx_data == 8'hAA) || (rx_data == 8'hEE) ||
                   (rx_data == 8'hFA) || (rx_data == 8'hFE) || (rx_data == 8'hFF);
        is_make  = 1'b0;
        is_break = 1'b0;
        ev_ext   = 1'b0;
        if (rx_valid && !ignored) begin
            case (state_q)
                S_IDLE: is_make = (rx_data != 8'hE0) && (rx_data != 8'hF0);
                S_E0: begin
                    is_make = (rx_data != 8'hE0) && (rx_data != 8'hF0);
                    ev_ext  = 1'b1;
                end
                S_F0:   is_break = 1'b1;
                S_E0F0: begin
                    is_break = 1'b1;
                    ev_ext   = 1'b1;
                end
                default: is_make = 1'b0;
            endcase
        end
        key = {ev_ext, rx_data};
    end

    // Slot search; scanning downward leaves the lowest matching index in each result.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = 3'd0;
        hit_age   = 3'd0;
        have_free = 1'b0;
        free_idx  = 3'd0;
        old_idx   = 3'd0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                have_free = 1'b1;
                free_idx  = 3'(i);
            end
            if (active_q[i] && (code_q[i] == key)) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
                hit_age = age_q[i];
            end
            if (active_q[i] && (age_q[i] == 3'(NUM_VOICES - 1))) begin
                old_idx = 3'(i);
            end
        end
        tgt_idx = have_free ? free_idx : old_idx;
    end

    // Next-state: prefix FSM, timeout, slot table and event pulses.
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        active_d     = active_q;
        code_d       = code_q;
        age_d        = age_q;
        last_code_d  = last_code_q;
        note_on_d    = 1'b0;
        note_off_d   = 1'b0;
        event_slot_d = event_slot_q;
        dropped_d    = 1'b0;

        if (rx_valid) begin
            tmo_d = '0;
            if (ignored) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_data == 8'hE0)      state_d = S_E0;
                        else if (rx_data == 8'hF0) state_d = S_F0;
                    end
                    S_E0: begin
                        if (rx_data == 8'hF0)      state_d = S_E0F0;
                        else if (rx_data == 8'hE0) state_d = S_E0;
                        else                       state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = S_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        // A replaced or newly filled slot becomes newest; every other held key ages by one.
        if (is_make && !hit) begin
            if (have_free || (STEAL != 0)) begin
                for (int j = 0; j < NUM_VOICES; j++) begin
                    if (3'(j) == tgt_idx) begin
                        active_d[j] = 1'b1;
                        code_d[j]   = key;
                        age_d[j]    = 3'd0;
                    end else if (active_q[j]) begin
                        age_d[j] = age_q[j] + 3'd1;
                    end
                end
                note_on_d    = 1'b1;
                event_slot_d = tgt_idx;
                last_code_d  = rx_data;
            end else begin
                dropped_d = 1'b1;
            end
        end

        if (is_break && hit) begin
            for (int j = 0; j < NUM_VOICES; j++) begin
                if (3'(j) == hit_idx) begin
                    active_d[j] = 1'b0;
                    code_d[j]   = 9'd0;
                    age_d[j]    = 3'd0;
                end else if (active_q[j] && (age_q[j] > hit_age)) begin
                    age_d[j] = age_q[j] - 3'd1;
                end
            end
            note_off_d   = 1'b1;
            event_slot_d = hit_idx;
        end

        if (all_off) begin
            state_d      = S_IDLE;
            tmo_d        = '0;
            active_d     = '0;
            code_d       = '0;
            age_d        = '0;
            last_code_d  = last_code_q;
            note_on_d    = 1'b0;
            note_off_d   = 1'b0;
            event_slot_d = event_slot_q;
            dropped_d    = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            active_q     <= '0;
            code_q       <= '0;
            age_q        <= '0;
            last_code_q  <= 8'd0;
            note_on_q    <= 1'b0;
            note_off_q   <= 1'b0;
            event_slot_q <= 3'd0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            active_q     <= active_d;
            code_q       <= code_d;
            age_q        <= age_d;
            last_code_q  <= last_code_d;
            note_on_q    <= note_on_d;
            note_off_q   <= note_off_d;
            event_slot_q <= event_slot_d;
            dropped_q    <= dropped_d;
        end
    end

    assign voice_active = active_q;
    assign voice_code   = code_q;
    assign last_code    = last_code_q;
    assign note_on      = note_on_q;
    assign note_off     = note_off_q;
    assign event_slot   = event_slot_q;
    assign dropped      = dropped_q;

endmodule

// File: tb/tb_ps2_voice_tracker.sv
// Directed bench for ps2_voice_tracker: a stealing and a dropping instance share stimulus.
module tb_ps2_voice_tracker;

    localparam int unsigned NV  = 4;
    localparam int unsigned TMO = 16;

    logic        clk;
    logic        resetn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        all_off;

    logic [NV-1:0]   s_active, d_active;
    logic [9*NV-1:0] s_code, d_code;
    logic [7:0]      s_last, d_last;
    logic            s_on, d_on, s_off, d_off, s_drop, d_drop;
    logic [2:0]      s_slot, d_slot;

    int n_chk  = 0;
    int n_pass = 0;

    ps2_voice_tracker #(.NUM_VOICES(NV), .STEAL(1), .TIMEOUT_CYC(TMO)) u_steal (
        .CLOCK_50(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
        .all_off(all_off), .voice_active(s_active), .voice_code(s_code),
        .last_code(s_last), .note_on(s_on), .note_off(s_off),
        .event_slot(s_slot), .dropped(s_drop)
    );

    ps2_voice_tracker #(.NUM_VOICES(NV), .STEAL(0), .TIMEOUT_CYC(TMO)) u_drop (
        .CLOCK_50(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
        .all_off(all_off), .voice_active(d_active), .voice_code(d_code),
        .last_code(d_last), .note_on(d_on), .note_off(d_off),
        .event_slot(d_slot), .dropped(d_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       aoff;
        logic [3:0] act;
        logic       on;
        logic       off;
        logic [2:0] slot;
        logic [7:0] last;
        logic [8:0] code0;
        logic       dd;
        logic [7:0] dlast;
        logic [8:0] dcode0;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] data, input logic aoff, input logic [3:0] act,
                                input logic on, input logic off, input logic [2:0] slot,
                                input logic [7:0] last, input logic [8:0] code0,
                                input logic dd, input logic [7:0] dlast, input logic [8:0] dcode0);
        vec_t v;
        v.data = data; v.aoff = aoff; v.act = act; v.on = on; v.off = off; v.slot = slot;
        v.last = last; v.code0 = code0; v.dd = dd; v.dlast = dlast; v.dcode0 = dcode0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_all();
        all_off = 1'b1;
        idle(1);
        all_off = 1'b0;
    endtask

    int on_cnt;

    initial begin
        resetn   = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        all_off  = 1'b0;

        // Table: steal-DUT expectations plus dropping-DUT dropped/last/slot0.
        vecs.push_back(mk(8'h1C, 0, 4'b0001, 1, 0, 3'd0, 8'h1C, 9'h01C, 0, 8'h1C, 9'h01C));
        vecs.push_back(mk(8'hF0, 0, 4'b0001, 0, 0, 3'd0, 8'h1C, 9'h01C, 0, 8'h1C, 9'h01C));
        vecs.push_back(mk(8'h1C, 0, 4'b0000, 0, 1, 3'd0, 8'h1C, 9'h000, 0, 8'h1C, 9'h000));
        vecs.push_back(mk(8'h1C, 0, 4'b0001, 1, 0, 3'd0, 8'h1C, 9'h01C, 0, 8'h1C, 9'h01C));
        vecs.push_back(mk(8'h1B, 0, 4'b0011, 1, 0, 3'd1, 8'h1B, 9'h01C, 0, 8'h1B, 9'h01C));
        vecs.push_back(mk(8'h23, 0, 4'b0111, 1, 0, 3'd2, 8'h23, 9'h01C, 0, 8'h23, 9'h01C));
        vecs.push_back(mk(8'h2B, 0, 4'b1111, 1, 0, 3'd3, 8'h2B, 9'h01C, 0, 8'h2B, 9'h01C));
        vecs.push_back(mk(8'h34, 0, 4'b1111, 1, 0, 3'd0, 8'h34, 9'h034, 1, 8'h2B, 9'h01C));
        vecs.push_back(mk(8'hAA, 0, 4'b1111, 0, 0, 3'd0, 8'h34, 9'h034, 0, 8'h2B, 9'h01C));
        vecs.push_back(mk(8'h1C, 1, 4'b0000, 0, 0, 3'd0, 8'h34, 9'h000, 0, 8'h2B, 9'h000));
        vecs.push_back(mk(8'hE0, 0, 4'b0000, 0, 0, 3'd0, 8'h34, 9'h000, 0, 8'h2B, 9'h000));
        vecs.push_back(mk(8'h75, 0, 4'b0001, 1, 0, 3'd0, 8'h75, 9'h175, 0, 8'h75, 9'h175));
        vecs.push_back(mk(8'hF0, 0, 4'b0001, 0, 0, 3'd0, 8'h75, 9'h175, 0, 8'h75, 9'h175));
        vecs.push_back(mk(8'h75, 0, 4'b0001, 0, 0, 3'd0, 8'h75, 9'h175, 0, 8'h75, 9'h175));
        vecs.push_back(mk(8'hE0, 0, 4'b0001, 0, 0, 3'd0, 8'h75, 9'h175, 0, 8'h75, 9'h175));
        vecs.push_back(mk(8'hF0, 0, 4'b0001, 0, 0, 3'd0, 8'h75, 9'h175, 0, 8'h75, 9'h175));
        vecs.push_back(mk(8'h75, 0, 4'b0000, 0, 1, 3'd0, 8'h75, 9'h000, 0, 8'h75, 9'h000));
        vecs.push_back(mk(8'hE0, 0, 4'b0000, 0, 0, 3'd0, 8'h75, 9'h000, 0, 8'h75, 9'h000));
        vecs.push_back(mk(8'hE0, 0, 4'b0000, 0, 0, 3'd0, 8'h75, 9'h000, 0, 8'h75, 9'h000));
        vecs.push_back(mk(8'h6B, 0, 4'b0001, 1, 0, 3'd0, 8'h6B, 9'h16B, 0, 8'h6B, 9'h16B));
        vecs.push_back(mk(8'h00, 1, 4'b0000, 0, 0, 3'd0, 8'h6B, 9'h000, 0, 8'h6B, 9'h000));

        #12;
        chk("reset_active", 64'(s_active), 64'd0);
        chk("reset_code",   64'(s_code),   64'd0);
        chk("reset_pulses", 64'({s_on, s_off, s_drop, s_slot}), 64'd0);
        chk("reset_last",   64'(s_last),   64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            all_off = vecs[k].aoff;
            send(vecs[k].data);
            all_off = 1'b0;
            chk($sformatf("v%0d_active", k), 64'(s_active), 64'(vecs[k].act));
            chk($sformatf("v%0d_note_on", k), 64'(s_on), 64'(vecs[k].on));
            chk($sformatf("v%0d_note_off", k), 64'(s_off), 64'(vecs[k].off));
            chk($sformatf("v%0d_slot", k), 64'(s_slot), 64'(vecs[k].slot));
            chk($sformatf("v%0d_last", k), 64'(s_last), 64'(vecs[k].last));
            chk($sformatf("v%0d_steal_dropped", k), 64'(s_drop), 64'd0);
            if (vecs[k].act[0]) chk($sformatf("v%0d_code0", k), 64'(s_code[8:0]), 64'(vecs[k].code0));
            chk($sformatf("v%0d_d_active", k), 64'(d_active), 64'(vecs[k].act));
            chk($sformatf("v%0d_d_dropped", k), 64'(d_drop), 64'(vecs[k].dd));
            chk($sformatf("v%0d_d_note_on", k), 64'(d_on), 64'(vecs[k].on & ~vecs[k].dd));
            chk($sformatf("v%0d_d_last", k), 64'(d_last), 64'(vecs[k].dlast));
            if (vecs[k].act[0]) chk($sformatf("v%0d_d_code0", k), 64'(d_code[8:0]), 64'(vecs[k].dcode0));
        end

        // Typematic repeat, back-to-back strobes.
        clear_all();
        on_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            send(8'h1C);
            if (s_on) on_cnt++;
        end
        idle(1);
        if (s_on) on_cnt++;
        chk("typematic_on_count", 64'(on_cnt), 64'd1);
        chk("typematic_active", 64'(s_active), 64'b0001);

        // Stale F0 prefix abandoned after timeout, next byte is a make.
        clear_all();
        send(8'hF0);
        idle(TMO + 4);
        send(8'h1C);
        chk("timeout_note_on", 64'(s_on), 64'd1);
        chk("timeout_active", 64'(s_active), 64'b0001);
        chk("timeout_code0", 64'(s_code[8:0]), 64'h01C);
        send(8'hF0);
        idle(5);
        send(8'h1C);
        chk("short_gap_note_off", 64'(s_off), 64'd1);
        chk("short_gap_active", 64'(s_active), 64'b0000);

        // Age ordering: free a middle slot, refill it, then steal twice.
        clear_all();
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
        send(8'hF0); send(8'h1B);
        chk("age_free_slot", 64'(s_slot), 64'd1);
        chk("age_free_active", 64'(s_active), 64'b1101);
        send(8'h34);
        chk("age_refill_slot", 64'(s_slot), 64'd1);
        chk("age_refill_on", 64'(s_on), 64'd1);
        send(8'h35);
        chk("age_steal1_slot", 64'(s_slot), 64'd0);
        chk("age_steal1_code", 64'(s_code[8:0]), 64'h035);
        chk("age_steal1_nooff", 64'(s_off), 64'd0);
        chk("age_drop_dropped", 64'(d_drop), 64'd1);
        send(8'h36);
        chk("age_steal2_slot", 64'(s_slot), 64'd2);
        chk("age_steal2_code", 64'(s_code[26:18]), 64'h036);
        chk("age_drop_code0", 64'(d_code[8:0]), 64'h01C);

        // Async reset mid-stream between F0 and the code byte.
        clear_all();
        send(8'h1C); send(8'h1B); send(8'hF0);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_active", 64'({s_active, d_active}), 64'd0);
        chk("midrst_code", 64'(s_code), 64'd0);
        chk("midrst_misc", 64'({s_last, s_on, s_off, s_slot, s_drop}), 64'd0);
        idle(1);
        resetn = 1'b1;
        idle(1);
        send(8'h1C);
        chk("postrst_on", 64'(s_on), 64'd1);
        chk("postrst_active", 64'(s_active), 64'b0001);
        chk("postrst_code0", 64'(s_code[8:0]), 64'h01C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
